// File: rtl/dm_pkg.sv
// dm_pkg: shared types and constants for the data-memory responder and the CPU MEM-stage port.
`default_nettype none

package dm_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    // Bit positions in the error-cause vector
    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_NO_BE    = 2;
    localparam int ERR_W        = 3;

    function automatic logic [ERR_W-1:0] dm_err_cause(
        input logic [WORD_W-1:0] addr,
        input logic [BE_W-1:0]   be,
        input logic [31:0]       depth
    );
        logic [ERR_W-1:0] cause;
        cause               = '0;
        cause[ERR_MISALIGN] = (addr[1:0] != 2'b00);
        cause[ERR_RANGE]    = ({2'b00, addr[31:2]} >= depth);
        cause[ERR_NO_BE]    = (be == '0);
        return cause;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dm_array.sv
// dm_array: DEPTH x 32-bit word store with per-lane byte writes, combinational read, async clear.
`default_nettype none

module dm_array
    import dm_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int l = 0; l < BE_W; l++) begin
                if (be_i[l]) begin
                    mem_q[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/dm_responder.sv
// dm_responder: single-outstanding load/store responder with programmable wait states.
`default_nettype none

module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int             AW  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

    dm_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic              accept;
    logic              do_access;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              acc_err;
    logic [31:0]       arr_rdata;
    logic [31:0]       resp_rdata_d;
    logic              resp_err_d;

    assign accept = (state_q == ST_IDLE) && req_valid && req_ready_q;

    // Zero-latency requests are serviced straight from the request bus on the accept edge.
    assign acc_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign acc_be    = (state_q == ST_IDLE) ? req_be    : be_q;

    assign do_access = (accept && (LAT == '0)) ||
                       ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));
    assign acc_err   = |dm_err_cause(acc_addr, acc_be, 32'(DEPTH));

    assign resp_err_d   = acc_err;
    assign resp_rdata_d = (acc_err || acc_we) ? '0 : arr_rdata;

    dm_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we_i    (do_access && acc_we && !acc_err),
        .addr_i  (acc_addr[AW+1:2]),
        .wdata_i (acc_wdata),
        .be_i    (acc_be),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        be_q        <= req_be;
                        cnt_q       <= LAT;
                        req_ready_q <= 1'b0;
                        if (LAT == '0) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= resp_rdata_d;
                            resp_err_q   <= resp_err_d;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                    if (do_access) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= resp_rdata_d;
                        resp_err_q   <= resp_err_d;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// tb_dm_responder: table-driven and scoreboarded checks of dm_responder at LATENCY 2 and 0.
`default_nettype none

module tb_dm_responder;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_be     [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int   n_checks;
    int   n_fail;
    exp_t sb_q [$];
    vec_t vecs [11];

    dm_responder #(.DEPTH(1024), .LATENCY(2)) u_dut0 (
        .clk        (clk),
        .reset      (rst_n[0]),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_we     (req_we[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .req_be     (req_be[0]),
        .resp_valid (resp_valid[0]),
        .resp_ready (resp_ready[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
    );

    dm_responder #(.DEPTH(1024), .LATENCY(0)) u_dut1 (
        .clk        (clk),
        .reset      (rst_n[1]),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_we     (req_we[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .req_be     (req_be[1]),
        .resp_valid (resp_valid[1]),
        .resp_ready (resp_ready[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int k, input int cycles);
        @(negedge clk);
        rst_n[k] = 1'b0;
        #1;
        check("reset req_ready low", 32'(req_ready[k]), 32'd0);
        check("reset resp_valid low", 32'(resp_valid[k]), 32'd0);
        repeat (cycles) @(negedge clk);
        rst_n[k] = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("post-reset req_ready", 32'(req_ready[k]), 32'd1);
        check("post-reset resp_valid", 32'(resp_valid[k]), 32'd0);
        check("post-reset resp_rdata", resp_rdata[k], 32'd0);
        check("post-reset resp_err", 32'(resp_err[k]), 32'd0);
    endtask

    // Present a request and return just after the accepting edge.
    task automatic issue(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, output bit ok);
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_be[k]    = be;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (req_ready[k]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            check("accept timeout", 32'd0, 32'd1);
        end
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_resp(input int k, input int exp_lat);
        int cyc;
        @(negedge clk);
        cyc = 1;
        while (!resp_valid[k] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("response latency", 32'(cyc), 32'(exp_lat));
    endtask

    task automatic complete(input int k);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("resp_valid", 32'(resp_valid[k]), 32'd1);
            check("resp_rdata", resp_rdata[k], e.rdata);
            check("resp_err", 32'(resp_err[k]), 32'(e.err));
        end
        resp_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[k] = 1'b0;
    endtask

    task automatic run(input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        bit   ok;
        exp_t e;
        issue(k, we, addr, wdata, be, ok);
        if (ok) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            sb_q.push_back(e);
            wait_resp(k, exp_lat);
            complete(k);
        end
    endtask

    initial begin
        bit   ok;
        bit   seen;
        exp_t e;
        n_checks = 0;
        n_fail   = 0;
        for (int k = 0; k < 2; k++) begin
            rst_n[k]      = 1'b0;
            req_valid[k]  = 1'b0;
            req_we[k]     = 1'b0;
            req_addr[k]   = '0;
            req_wdata[k]  = '0;
            req_be[k]     = '0;
            resp_ready[k] = 1'b0;
        end

        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         4'b1111, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0010, 32'h0000_AA00, 4'b0010, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'hDEAD_AAEF, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0011, 32'h0,         4'b1111, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'b1111, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0FFC, 32'h5500_0000, 4'b1000, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'b1111, 32'h5500_0000, 1'b0};

        do_reset(0, 10);
        for (int i = 0; i < 11; i++) begin
            run(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                vecs[i].exp_rdata, vecs[i].exp_err, 3);
        end

        // Back-pressure: response held 5 cycles while a second request waits.
        issue(0, 1'b0, 32'h10, 32'h0, 4'b1111, ok);
        e.rdata = 32'hDEAD_AAEF;
        e.err   = 1'b0;
        sb_q.push_back(e);
        wait_resp(0, 3);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h0;
        req_be[0]    = 4'b1111;
        req_we[0]    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold resp_valid", 32'(resp_valid[0]), 32'd1);
            check("hold resp_rdata", resp_rdata[0], 32'hDEAD_AAEF);
            check("hold req_ready", 32'(req_ready[0]), 32'd0);
            @(negedge clk);
        end
        complete(0);
        @(negedge clk);
        check("after handshake req_ready", 32'(req_ready[0]), 32'd0);
        check("after handshake resp_valid", 32'(resp_valid[0]), 32'd0);
        @(negedge clk);
        check("second cycle req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        sb_q.push_back(e);
        wait_resp(0, 3);
        complete(0);

        // Reset during WAIT drops the pending store and clears the array.
        issue(0, 1'b1, 32'h20, 32'h1234_5678, 4'b1111, ok);
        @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        check("mid-wait reset resp_valid", 32'(resp_valid[0]), 32'd0);
        check("mid-wait reset req_ready", 32'(req_ready[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid[0]) seen = 1'b1;
        end
        check("dropped store no response", 32'(seen), 32'd0);
        run(0, 1'b0, 32'h20, 32'h0, 4'b1111, 32'h0, 1'b0, 3);
        run(0, 1'b0, 32'h10, 32'h0, 4'b1111, 32'h0, 1'b0, 3);

        // Zero wait states.
        do_reset(1, 3);
        run(1, 1'b1, 32'h20, 32'h1234_5678, 4'b1111, 32'h0, 1'b0, 1);
        run(1, 1'b0, 32'h20, 32'h0, 4'b1111, 32'h1234_5678, 1'b0, 1);
        run(1, 1'b0, 32'h22, 32'h0, 4'b1111, 32'h0, 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
